// File: rtl/fault_campaign_scheduler_pkg.sv
// Shared types and constants for the fault campaign scheduler: FSM encoding,
// fault-word component codes and field positions.
package fault_campaign_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_LOAD = 3'd2,
        ST_ARM  = 3'd3,
        ST_FIRE = 3'd4
    } sched_state_t;

    localparam logic [3:0] FI_COMP_REGFILE = 4'h0;
    localparam logic [3:0] FI_COMP_MEMORY  = 4'h2;

    localparam int FW_COMP_LSB = 28;
    localparam int FW_REG_LSB  = 19;
    localparam int FW_BIT_LSB  = 14;

    typedef struct packed {
        logic [3:0]  comp;
        logic [3:0]  rsvd_hi;
        logic [4:0]  target;
        logic [4:0]  bit_sel;
        logic [13:0] rsvd_lo;
    } fault_word_t;

    function automatic logic [3:0] fault_comp(input logic [31:0] word);
        return word[FW_COMP_LSB +: 4];
    endfunction

endpackage

// File: rtl/fault_sched_fifo.sv
// Count-based FIFO holding {trigger_step, fault_instruction} entries; flush
// overrides push/pop. Caller guarantees no push when full (unless popping).
module fault_sched_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    // Pointers are AW bits wide, so increment wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

endmodule

// File: rtl/fault_campaign_scheduler.sv
// Fires queued faults into fault_injection when the retire count reaches each
// entry's step. `FAULT_SCHED_TIMESTAMP_EN adds last_fire_step/last_fire_comp.
module fault_campaign_scheduler
    import fault_campaign_scheduler_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [CNT_W-1:0]           push_step,
    input  logic [31:0]                push_instr,
    input  logic                       core_step,
    output logic                       core_stall,
    output logic                       fi_enable,
    output logic [31:0]                fi_instruction,
    output logic                       fi_trigger,
    input  logic                       fi_active,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     queue_level,
`ifdef FAULT_SCHED_TIMESTAMP_EN
    output logic [CNT_W-1:0]           last_fire_step,
    output logic [3:0]                 last_fire_comp,
`endif
    output logic                       overflow,
    output logic                       late,
    output logic [7:0]                 fired_count
);
    localparam int EW = CNT_W + 32;

    sched_state_t     state;
    logic [CNT_W-1:0] step_cnt;
    logic             stall_r;
    logic [EW-1:0]    head;
    logic [CNT_W-1:0] head_step;
    logic [31:0]      head_instr;
    logic             full;
    logic             empty;
    logic             fire_pop;
    logic             push_acc;
    logic             match;

    assign head_step  = head[EW-1:32];
    assign head_instr = head[31:0];

    assign fire_pop   = (state == ST_FIRE);
    assign push_ready = !full || fire_pop;
    assign push_acc   = push_valid && push_ready && !abort;
    assign match      = (state == ST_WAIT) && !empty && (step_cnt >= head_step);
    // Stall must rise in the match cycle itself so no retire slips past the fault.
    assign core_stall = stall_r || match;
    assign busy       = (state != ST_IDLE);

    fault_sched_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (abort),
        .push  (push_acc),
        .pop   (fire_pop),
        .din   ({push_step, push_instr}),
        .head  (head),
        .count (queue_level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            step_cnt       <= '0;
            stall_r        <= 1'b0;
            fi_enable      <= 1'b0;
            fi_trigger     <= 1'b0;
            fi_instruction <= '0;
            done           <= 1'b0;
            overflow       <= 1'b0;
            late           <= 1'b0;
            fired_count    <= '0;
        end else begin
            if (push_valid && !push_ready) overflow <= 1'b1;
            if (abort) begin
                state          <= ST_IDLE;
                stall_r        <= 1'b0;
                fi_enable      <= 1'b0;
                fi_trigger     <= 1'b0;
                fi_instruction <= '0;
            end else begin
                case (state)
                    ST_IDLE: if (start) begin
                        step_cnt    <= '0;
                        fired_count <= '0;
                        late        <= 1'b0;
                        state       <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (core_step && step_cnt != '1) step_cnt <= step_cnt + CNT_W'(1);
                        if (empty) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else if (match) begin
                            if (step_cnt > head_step) late <= 1'b1;
                            fi_enable      <= 1'b1;
                            fi_instruction <= head_instr;
                            stall_r        <= 1'b1;
                            state          <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        fi_enable <= 1'b0;
                        state     <= ST_ARM;
                    end
                    ST_ARM: begin
                        fi_trigger <= 1'b1;
                        state      <= ST_FIRE;
                    end
                    ST_FIRE: begin
                        fi_trigger     <= 1'b0;
                        stall_r        <= 1'b0;
                        fi_instruction <= '0;
                        if (fired_count != 8'hFF) fired_count <= fired_count + 8'd1;
                        state          <= ST_WAIT;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef FAULT_SCHED_TIMESTAMP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_fire_step <= '0;
            last_fire_comp <= '0;
        end else if (fire_pop && !abort) begin
            last_fire_step <= step_cnt;
            last_fire_comp <= fault_comp(fi_instruction);
        end
    end
`endif

    // fault_injection must acknowledge a trigger on the following cycle.
    fire_then_active: assert property (@(posedge clk) disable iff (!rst_n)
        fi_trigger |=> fi_active);

endmodule

// File: tb/tb_fault_campaign_scheduler.sv
// Self-checking bench: directed campaigns plus randomized queues checked
// against an order/step model of the fault campaign.
module tb_fault_campaign_scheduler;
    localparam int DEPTH = 8;
    localparam int CNT_W = 32;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic push_valid = 1'b0, core_step = 1'b0, fi_active = 1'b0;
    logic [CNT_W-1:0] push_step = '0;
    logic [31:0] push_instr = '0;
    logic push_ready, core_stall, fi_enable, fi_trigger, busy, done, overflow, late;
    logic [31:0] fi_instruction;
    logic [$clog2(DEPTH):0] queue_level;
    logic [7:0] fired_count;
`ifdef FAULT_SCHED_TIMESTAMP_EN
    logic [CNT_W-1:0] last_fire_step;
    logic [3:0] last_fire_comp;
`endif

    fault_campaign_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_step(push_step), .push_instr(push_instr),
        .core_step(core_step), .core_stall(core_stall),
        .fi_enable(fi_enable), .fi_instruction(fi_instruction),
        .fi_trigger(fi_trigger), .fi_active(fi_active),
        .busy(busy), .done(done), .queue_level(queue_level),
`ifdef FAULT_SCHED_TIMESTAMP_EN
        .last_fire_step(last_fire_step), .last_fire_comp(last_fire_comp),
`endif
        .overflow(overflow), .late(late), .fired_count(fired_count)
    );

    always #5 clk = ~clk;

    // fault_injection stand-in: active the cycle after a trigger.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) fi_active <= 1'b0;
        else        fi_active <= fi_trigger;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] step;
        logic [31:0] instr;
    } ent_t;

    ent_t exp_q[$];

    task automatic push_entry(input logic [31:0] s, input logic [31:0] ins);
        ent_t e;
        e.step = s;
        e.instr = ins;
        push_valid = 1'b1;
        push_step = s;
        push_instr = ins;
        check("push_ready", 64'(push_ready), 64'(exp_q.size() < DEPTH));
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        @(posedge clk); #1;
        push_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drives a retiring core until every queued entry has fired. Each fire must
    // come in queue order at retire count max(previous fire step, entry step).
    task automatic run_campaign(input int pct, input bit inj, input ent_t inj_e, output int max_run);
        int n_fire, fires, cyc, en_cyc, run, run_fires;
        logic [31:0] retired, prev_s, s;
        bit late_exp, injected, finished;
        ent_t e;
        n_fire = exp_q.size() + int'(inj);
        fires = 0; cyc = 0; en_cyc = -100; run = 0; run_fires = 0;
        retired = 0; prev_s = 0; late_exp = 0; injected = 0; finished = 0;
        max_run = 0;
        pulse_start();
        for (int k = 0; k < 3000 && !finished; k++) begin
            push_valid = 1'b0;
            if (fi_enable) begin
                en_cyc = cyc;
                if (inj && !injected) begin
                    push_valid = 1'b1;
                    push_step = inj_e.step;
                    push_instr = inj_e.instr;
                    exp_q.push_back(inj_e);
                    injected = 1;
                end
            end
            if (fi_trigger) begin
                if (exp_q.size() == 0) check("fire_unexpected", 64'(fi_trigger), 64'd0);
                else begin
                    e = exp_q.pop_front();
                    s = (prev_s > e.step) ? prev_s : e.step;
                    if (prev_s > e.step) late_exp = 1;
                    prev_s = s;
                    check("fire_instr", 64'(fi_instruction), 64'(e.instr));
                    check("fire_step", 64'(retired), 64'(s));
                    check("en_to_trig", 64'(cyc - en_cyc), 64'd2);
                end
                fires++;
                run_fires++;
            end
            if (core_stall) run++;
            else if (run > 0) begin
                check("stall_len", 64'(run), 64'(4 * run_fires));
                if (run > max_run) max_run = run;
                run = 0;
                run_fires = 0;
            end
            if (!busy && fires == n_fire) finished = 1;
            core_step = (!core_stall && busy && fires < n_fire && $urandom_range(99) < pct);
            if (core_step) retired++;
            @(posedge clk); #1;
            cyc++;
        end
        core_step = 1'b0;
        push_valid = 1'b0;
        check("campaign_finished", 64'(finished), 64'd1);
        check("fired_count", 64'(fired_count), 64'(n_fire));
        check("done", 64'(done), 64'd1);
        check("late", 64'(late), 64'(late_exp));
        check("queue_empty", 64'(queue_level), 64'd0);
    endtask

    initial begin
        ent_t none;
        int mr, n;
        bit saw;
        none.step = 0;
        none.instr = 0;

        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_outs", {fi_trigger, fi_enable, core_stall, busy, done, overflow, late,
                             fi_instruction, fired_count, queue_level}, 64'd0);
        check("reset_push_ready", 64'(push_ready), 64'd1);

        // single fault at step 5
        push_entry(5, 32'h0028_0000);
        run_campaign(100, 0, none, mr);
        check("single_late", 64'(late), 64'd0);

        // equal steps back-to-back, then a later step
        push_entry(3, 32'hA000_0001);
        push_entry(3, 32'hB000_0002);
        push_entry(7, 32'hC000_0003);
        run_campaign(100, 0, none, mr);
        check("stall_ab_window", 64'(mr), 64'd8);

        // entry arriving after its step has passed fires immediately and is late
        begin
            ent_t x;
            x.step = 4;
            x.instr = 32'h2010_4000;
            push_entry(20, 32'h0100_0000);
            run_campaign(100, 1, x, mr);
            check("late_set", 64'(late), 64'd1);
        end

        // overflow on the ninth push while idle
        for (int i = 0; i < 9; i++) push_entry(32'(i * 2), 32'h1000_0000 + 32'(i));
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_level", 64'(queue_level), 64'd8);
        run_campaign(60, 0, none, mr);

        // randomized queues
        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) push_entry($urandom_range(0, 40), $urandom);
            run_campaign($urandom_range(20, 100), 0, none, mr);
        end

        // abort with fi_enable just dropped (ARM)
        push_entry(2, 32'h0028_0000);
        push_entry(9, 32'h2000_0000);
        pulse_start();
        for (int k = 0; k < 200 && !fi_enable; k++) begin
            core_step = !core_stall;
            @(posedge clk); #1;
        end
        core_step = 1'b0;
        check("abort_reached_load", 64'(fi_enable), 64'd1);
        @(posedge clk); #1;
        check("arm_enable_low", 64'(fi_enable), 64'd0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_level", 64'(queue_level), 64'd0);
        check("abort_outs", {core_stall, fi_enable, fi_trigger, fi_instruction}, 64'd0);
        saw = 0;
        repeat (6) begin
            if (fi_trigger) saw = 1;
            @(posedge clk); #1;
        end
        check("abort_no_trigger", 64'(saw), 64'd0);
        exp_q.delete();

        // asynchronous reset in FIRE
        push_entry(1, 32'h2050_8000);
        pulse_start();
        for (int k = 0; k < 200 && !fi_trigger; k++) begin
            core_step = !core_stall && busy;
            @(posedge clk); #1;
        end
        core_step = 1'b0;
        check("rst_reached_fire", 64'(fi_trigger), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_outs", {fi_trigger, fi_enable, core_stall, busy, done, overflow, late,
                                 fi_instruction, fired_count, queue_level}, 64'd0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_fired_count", 64'(fired_count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
